lsu_bus_master: RTL
===================

# lsu_bus_master

Load/store unit in the CPU MEM stage and the initiator side of the data-memory interface. It takes one load/store request from the pipeline, checks alignment, and generates a word-aligned address, byte enables and lane-replicated write data. It runs a req/ack handshake with a variable-latency data memory, then returns sign- or zero-extended load data. The pipeline is stalled while a transaction is outstanding.

## Interface
- `TIMEOUT_CYC`, default 16: maximum BUSY cycles waiting for `mem_ack` before a bus error is reported.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: the pipeline presents a memory op. Held stable, with its operands, while `stall`=1.
- `req_op` in 3: op code from `lsu_pkg`.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data. The low byte/half/word is used according to `req_op`.
- `stall` out 1: freezes the pipeline.
- `rdata` out 32: extended load data. Valid only when `rdata_valid`=1.
- `rdata_valid` out 1: one-cycle completion pulse. It also pulses for stores.
- `exc` out 1: exception flag, qualified by `rdata_valid`.
- `exc_code` out 5: 4=AdEL, 5=AdES, 7=DBE. 0 when there is no exception.
- `mem_req` out 1: transaction request. Held high until ack.
- `mem_we` out 1: 1=write.
- `mem_addr` out 32: `{req_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables. Bit i corresponds to byte address offset i and to data bits [8i+7:8i] (little-endian).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: one-cycle acknowledge from memory. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
- Op codes: LW=0, LB=1, LBU=2, LH=3, LHU=4, SW=5, SH=6, SB=7. Ops 5–7 are writes.
- States:
  - IDLE: waiting for a request.
  - BUSY: `mem_req` high, waiting for ack.
  - RESP: result presented for one cycle.
- Alignment rules:
  - Word ops require `addr[1:0]`=0.
  - Half ops require `addr[0]`=0.
  - Byte ops are always aligned.
- IDLE, `req_valid` and aligned: register the memory-side outputs and go to BUSY.
- IDLE, `req_valid` and misaligned: no memory transaction. Go to RESP with `exc`=1 and code 4 (load) or 5 (store).
- BUSY, `mem_ack`=1:
  - Capture the extended load data.
  - Drop `mem_req` and go to RESP.
- BUSY, no ack for `TIMEOUT_CYC` consecutive cycles: drop `mem_req` and go to RESP with `exc`=1, code 7.
- RESP: `rdata_valid`=1, then return to IDLE. A new request may be accepted in the following IDLE cycle.
- Byte enables:
  - SW: 1111.
  - SH: 0011 << (2·`addr[1]`).
  - SB: 0001 << `addr[1:0]`.
  - Loads: the same masks by size (LW=1111; LH/LHU like SH; LB/LBU like SB).
- Write data:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: `wdata`.
- Load extraction:
  - Byte: `mem_rdata[8·addr[1:0]+7 -: 8]`.
  - Half: `mem_rdata[16·addr[1]+15 -: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `mem_ack` outside BUSY is ignored.
- `rdata` holds its value outside RESP.

## Timing
- `stall` = (IDLE & `req_valid`) | BUSY. It is 0 in RESP, so the pipeline advances on the edge that ends RESP.
- Minimum latency, ack in the first BUSY cycle:
  - `req_valid` in cycle 0.
  - BUSY in cycle 1.
  - RESP in cycle 2, with `rdata_valid`.
  - Total 3 cycles.
- Misaligned latency: 2 cycles (IDLE → RESP).
- Memory-side outputs are registered and constant for the whole of BUSY.
- Timeout counter:
  - Cleared on entry to BUSY.
  - Error fires on the cycle the count reaches `TIMEOUT_CYC`.
  - An ack in that same cycle wins: normal completion.
- Reset values:
  - State IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - `rdata`=0, `rdata_valid`=0, `exc`=0, `exc_code`=0.
  - Timeout counter 0.
- Reset mid-transaction: `mem_req` is 0 after the reset edge. A late ack is then discarded as an ack in IDLE.

## Structure
- `lsu_pkg` holds:
  - Op codes.
  - State encoding.
  - Exception codes (AdEL/AdES/DBE).
  - An `is_store` helper constant mask.
- Sub-module `lsu_align` (combinational) computes `mem_be`, `mem_wdata`, the misalign flag and the load-extract path. The FSM and timeout counter live in the top module.

## Test plan
- LW at 0x10, memory acks after 2 cycles with 0xDEADBEEF → BUSY for 2 cycles, then `rdata`=0xDEADBEEF, `exc`=0, `stall` low in RESP.
- SB at 0x13 with `wdata`=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x10, `mem_we`=1.
- LB at 0x12, `mem_rdata`=0x00800000 → `rdata`=0xFFFFFF80. LBU at the same address → `rdata`=0x00000080. LH at 0x12 with 0x80010000 → `rdata`=0xFFFF8001.
- LW at 0x02 → no `mem_req`, RESP with `exc`=1, code 4. SH at 0x05 → code 5.
- SW with no ack for 16 cycles → `mem_req` falls, `exc`=1, code 7. A stray ack 2 cycles later has no effect.
- Assert `rst` during BUSY → next cycle: IDLE, `mem_req`=0, all outputs 0. A following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op codes, FSM states and exception codes shared by the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LBU = 3'd2,
        OP_LH  = 3'd3,
        OP_LHU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Bit n set when op code n writes memory.
    localparam logic [7:0] STORE_MASK = 8'b1110_0000;

    function automatic logic is_store(input logic [2:0] op);
        return STORE_MASK[op];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, write-lane replication, misalign check and load extraction
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be       = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_wdata[7:0]}};
        o_misalign = 1'b0;
        case (lsu_op_e'(i_op))
            OP_LW, OP_SW: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_misalign = |i_addr_lo;
            end
            OP_LH, OP_LHU, OP_SH: begin
                o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            default: ;
        endcase
    end

    // Extraction uses the op/offset latched at accept, not the live request.
    always_comb begin
        w_byte = i_rdata[{i_ld_addr_lo, 3'b000} +: 8];
        w_half = i_rdata[{i_ld_addr_lo[1], 4'b0000} +: 16];
        case (lsu_op_e'(i_ld_op))
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'd0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'd0, w_half};
            default: o_load = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - MEM-stage load/store unit driving a req/ack data-memory interface
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic        r_mem_req, r_mem_we, r_exc;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rdata;
    logic [3:0]  r_mem_be;
    logic [4:0]  r_exc_code;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic        w_misalign, w_timeout;

    lsu_align u_align (
        .i_op         (req_op),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .i_ld_op      (r_op),
        .i_ld_addr_lo (r_addr_lo),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misalign   (w_misalign),
        .o_load       (w_load)
    );

    // Counter holds BUSY cycles already spent, so the last allowed cycle sees TIMEOUT_CYC-1.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = w_misalign ? ST_RESP : ST_BUSY;
            ST_BUSY: if (mem_ack || w_timeout) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall       = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_BUSY);
        rdata_valid = (r_state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_op        <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_exc       <= 1'b0;
            r_exc_code  <= EXC_NONE;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_op      <= req_op;
                    r_addr_lo <= req_addr[1:0];
                    r_cnt     <= '0;
                    if (w_misalign) begin
                        r_exc      <= 1'b1;
                        r_exc_code <= is_store(req_op) ? EXC_ADES : EXC_ADEL;
                    end else begin
                        r_exc       <= 1'b0;
                        r_exc_code  <= EXC_NONE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= is_store(req_op);
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!is_store(r_op)) r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_mem_req  <= 1'b0;
                        r_exc      <= 1'b1;
                        r_exc_code <= EXC_DBE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign exc       = r_exc;
    assign exc_code  = r_exc_code;

endmodule
